// File: rtl/freq_div_multi_pkg.sv
// Shared defaults and types for the multi-channel programmable clock divider.
// Optional 50% odd-divisor duty is selected with the FDIV_ODD_DUTY50_EN macro.
package freq_div_multi_pkg;

   localparam int unsigned FDIV_DEF_WIDTH     = 8;
   localparam int unsigned FDIV_DEF_CHANNELS  = 2;
   localparam int unsigned FDIV_DEF_RESET_DIV = 2;

   typedef enum logic {
      MODE_DIV    = 1'b0,
      MODE_BYPASS = 1'b1
   } fdiv_mode_e;

endpackage

// File: rtl/freq_div_multi_channel.sv
// One divider channel: active/shadow divisor, period counter, divided clock and tick.
// Define FDIV_ODD_DUTY50_EN to add a negedge stage giving 50% duty on odd divisors.
module fdiv_channel
   import freq_div_multi_pkg::*;
#(
   parameter int unsigned WIDTH     = FDIV_DEF_WIDTH,
   parameter int unsigned RESET_DIV = FDIV_DEF_RESET_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             div_pend,
   output logic             clk_out,
   output logic             tick
);

   logic [WIDTH-1:0] p_q, s_q, cnt_q;
   logic [WIDTH-1:0] p_nxt, cnt_nxt, h_nxt;
   logic             out_q, tick_q, pend_q;
   logic             wrap;
   fdiv_mode_e       mode;

   // Compare in WIDTH+1 bits so P=0 and the all-ones reset count both wrap.
   always_comb begin
      wrap    = ({1'b0, cnt_q} + (WIDTH+1)'(1)) >= {1'b0, p_q};
      p_nxt   = (wrap && pend_q) ? s_q : p_q;
      cnt_nxt = wrap ? '0 : cnt_q + WIDTH'(1);
      h_nxt   = p_nxt - (p_nxt >> 1);
      mode    = (p_q < WIDTH'(2)) ? MODE_BYPASS : MODE_DIV;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         p_q    <= WIDTH'(RESET_DIV);
         s_q    <= WIDTH'(RESET_DIV);
         cnt_q  <= '1;
         out_q  <= 1'b0;
         tick_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         p_q    <= p_nxt;
         cnt_q  <= cnt_nxt;
         out_q  <= (cnt_nxt < h_nxt);
         tick_q <= (cnt_nxt == '0);
         pend_q <= div_load | (pend_q & ~wrap);
         if (div_load) s_q <= div_val;
      end
   end

`ifdef FDIV_ODD_DUTY50_EN
   logic out_n;

   always_ff @(negedge clk) begin
      if (!reset) out_n <= 1'b0;
      else        out_n <= out_q;
   end

   always_comb begin
      if (mode == MODE_BYPASS)  clk_out = clk;
      else if (p_q[0])          clk_out = out_q & out_n;
      else                      clk_out = out_q;
   end
`else
   always_comb begin
      if (mode == MODE_BYPASS)  clk_out = clk;
      else                      clk_out = out_q;
   end
`endif

   assign tick     = (mode == MODE_BYPASS) | tick_q;
   assign div_pend = pend_q;

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider top: slices div_val and instantiates one channel each.
// Optional 50% odd-divisor duty via FDIV_ODD_DUTY50_EN (handled inside fdiv_channel).
module freq_div_multi
   import freq_div_multi_pkg::*;
#(
   parameter int unsigned WIDTH     = FDIV_DEF_WIDTH,
   parameter int unsigned CHANNELS  = FDIV_DEF_CHANNELS,
   parameter int unsigned RESET_DIV = FDIV_DEF_RESET_DIV
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] div_val,
   input  logic [CHANNELS-1:0]       div_load,
   output logic [CHANNELS-1:0]       div_pend,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS-1:0]       tick
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      fdiv_channel #(
         .WIDTH     (WIDTH),
         .RESET_DIV (RESET_DIV)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .div_val  (div_val[i*WIDTH +: WIDTH]),
         .div_load (div_load[i]),
         .div_pend (div_pend[i]),
         .clk_out  (clk_out[i]),
         .tick     (tick[i])
      );
   end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi with a period-position model checked every half cycle.
module tb_freq_div_multi;

   localparam int W  = 8;
   localparam int CH = 2;
   localparam int RD = 2;
`ifdef FDIV_ODD_DUTY50_EN
   localparam bit DUTY50 = 1'b1;
`else
   localparam bit DUTY50 = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [CH*W-1:0] div_val;
   logic [CH-1:0]   div_load;
   logic [CH-1:0]   div_pend;
   logic [CH-1:0]   clk_out;
   logic [CH-1:0]   tick;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   freq_div_multi #(.WIDTH(W), .CHANNELS(CH), .RESET_DIV(RD)) dut (
      .clk      (clk),
      .reset    (reset),
      .div_val  (div_val),
      .div_load (div_load),
      .div_pend (div_pend),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   // Model: each channel sits at position pos within a period of length per.
   int per[CH], shadow[CH], pos[CH];
   bit pend[CH], mout[CH], mprev[CH], mtick[CH];

   always @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         mprev[c] = mout[c];
         if (!reset) begin
            per[c] = RD; shadow[c] = RD; pos[c] = -1;
            pend[c] = 1'b0; mout[c] = 1'b0; mtick[c] = 1'b0;
         end else begin
            if (pos[c] < 0 || pos[c] + 1 >= per[c]) begin
               if (pend[c]) per[c] = shadow[c];
               pend[c] = 1'b0;
               pos[c]  = 0;
            end else begin
               pos[c]++;
            end
            if (div_load[c]) begin
               shadow[c] = int'(div_val[c*W +: W]);
               pend[c]   = 1'b1;
            end
            mout[c]  = pos[c] < (per[c] + 1) / 2;
            mtick[c] = (pos[c] == 0);
         end
      end
   end

   function automatic bit exp_clk(input int c, input bit clk_high);
      if (per[c] < 2) return clk_high;
      if (clk_high && DUTY50 && (per[c] % 2 == 1)) return mout[c] & mprev[c];
      return mout[c];
   endfunction

   // Single compare process: full check after posedge, clk_out check after negedge.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
               chk($sformatf("model_clk_out_hi[%0d]", c), 32'(clk_out[c]), 32'(exp_clk(c, 1'b1)));
               chk($sformatf("model_tick[%0d]", c), 32'(tick[c]), 32'((per[c] < 2) | mtick[c]));
               chk($sformatf("model_pend[%0d]", c), 32'(div_pend[c]), 32'(pend[c]));
            end
         end
         @(negedge clk); #1;
         if (chk_en) begin
            for (int c = 0; c < CH; c++)
               chk($sformatf("model_clk_out_lo[%0d]", c), 32'(clk_out[c]), 32'(exp_clk(c, 1'b0)));
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic load(input int c, input int v);
      div_val[c*W +: W] = W'(v);
      div_load[c] = 1'b1;
      step();
      div_load = '0;
   endtask

   // Wait for the next tick, then count cycles and high samples until the one after.
   task automatic measure(input int c, output int w, output int n, output int hi);
      w = 0;
      do begin step(); w++; end while (!tick[c] && w < 300);
      n = 0; hi = 0;
      do begin hi += int'(clk_out[c]); n++; step(); end while (!tick[c] && n < 300);
   endtask

   int w, n, hi;

   initial begin
      reset = 1'b0; div_val = '0; div_load = '0;
      step();
      chk_en = 1'b1;
      step(); step();
      chk("rst_clk_out", 32'(clk_out), 32'(0));
      chk("rst_tick", 32'(tick), 32'(0));
      chk("rst_pend", 32'(div_pend), 32'(0));

      // Div-by-2 after release: first tick one clk later.
      reset = 1'b1;
      step();
      chk("t1_first_clk", 32'(clk_out[0]), 32'(1));
      chk("t1_first_tick", 32'(tick[0]), 32'(1));
      step();
      chk("t1_second_clk", 32'(clk_out[0]), 32'(0));
      chk("t1_second_tick", 32'(tick[0]), 32'(0));
      step();
      chk("t1_third_tick", 32'(tick[0]), 32'(1));

      // Load 6 mid-period on ch0.
      load(0, 6);
      chk("t2_pend", 32'(div_pend), 32'(1));
      step();
      chk("t2_pend_clr", 32'(div_pend), 32'(0));
      chk("t2_wrap_tick", 32'(tick[0]), 32'(1));
      measure(0, w, n, hi);
      chk("t2_wait", 32'(w), 32'(6));
      chk("t2_period", 32'(n), 32'(6));
      chk("t2_high", 32'(hi), 32'(3));
      measure(1, w, n, hi);
      chk("t2_ch1_period", 32'(n), 32'(2));
      chk("t2_ch1_high", 32'(hi), 32'(1));

      // Odd divisor 5.
      load(0, 5);
      measure(0, w, n, hi);
      chk("t3_period", 32'(n), 32'(5));
      chk("t3_high", 32'(hi), DUTY50 ? 32'(2) : 32'(3));

      // Bypass via 1 then 0, then back to 4.
      load(0, 1);
      repeat (6) step();
      chk("t4_byp1_tick", 32'(tick[0]), 32'(1));
      chk("t4_byp1_clk", 32'(clk_out[0]), 32'(1));
      load(0, 0);
      repeat (3) step();
      chk("t4_byp0_tick", 32'(tick[0]), 32'(1));
      load(0, 4);
      chk("t4_load4_pend", 32'(div_pend[0]), 32'(1));
      step();
      chk("t4_div4_tick", 32'(tick[0]), 32'(1));
      chk("t4_div4_pend", 32'(div_pend[0]), 32'(0));
      measure(0, w, n, hi);
      chk("t4_wait", 32'(w), 32'(4));
      chk("t4_period", 32'(n), 32'(4));
      chk("t4_high", 32'(hi), 32'(2));

      // Load 7 on the wrap edge: deferred one full period.
      repeat (3) step();
      load(0, 7);
      chk("t5_wrap_tick", 32'(tick[0]), 32'(1));
      chk("t5_pend_kept", 32'(div_pend[0]), 32'(1));
      measure(0, w, n, hi);
      chk("t5_wait4", 32'(w), 32'(4));
      chk("t5_period7", 32'(n), 32'(7));
      chk("t5_high7", 32'(hi), DUTY50 ? 32'(3) : 32'(4));
      step();
      load(0, 3);
      step();
      load(0, 9);
      chk("t5_pend_9", 32'(div_pend[0]), 32'(1));
      measure(0, w, n, hi);
      chk("t5_period9", 32'(n), 32'(9));
      chk("t5_high9", 32'(hi), DUTY50 ? 32'(4) : 32'(5));

      // Reset mid-period with a pending load on ch1.
      load(1, 20);
      chk("t6_pend_before", 32'(div_pend[1]), 32'(1));
      reset = 1'b0;
      step();
      chk("t6_rst_clk", 32'(clk_out), 32'(0));
      chk("t6_rst_tick", 32'(tick), 32'(0));
      chk("t6_rst_pend", 32'(div_pend), 32'(0));
      reset = 1'b1;
      measure(1, w, n, hi);
      chk("t6_ch1_wait", 32'(w), 32'(1));
      chk("t6_ch1_period", 32'(n), 32'(2));
      measure(0, w, n, hi);
      chk("t6_ch0_period", 32'(n), 32'(2));

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
